// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: memory request/response, redirect, and decode-side head of queue.
// The queue drives through the master modport; the memory/decode environment uses slave.
interface fetch_queue_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  inst_ren;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic                  inst_rvalid;
  logic [DATA_WIDTH-1:0] inst_data;
  logic                  id_en;
  logic                  id_valid;
  logic [DATA_WIDTH-1:0] id_inst;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [ADDR_WIDTH-1:0] id_pc_next;
  logic [CNT_W-1:0]      count;

  modport master (
    input  redirect, redirect_addr, inst_rvalid, inst_data, id_en,
    output inst_ren, inst_addr, id_valid, id_inst, id_pc, id_pc_next, count
  );

  modport slave (
    output redirect, redirect_addr, inst_rvalid, inst_data, id_en,
    input  inst_ren, inst_addr, id_valid, id_inst, id_pc, id_pc_next, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding request, responses pushed into a DEPTH-entry registered queue.
// Head appears the cycle after inst_rvalid; fetching stalls while the queue would be full, id_en pops.
module fetch_queue #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.master bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
  } entry_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic                  head_vld_q, head_vld_d;
  entry_t                head_q, head_d;
  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [OCC_W-1:0]      occ_next;
  logic [OCC_W-1:0]      remain;
  entry_t                push_ent;

  // Handshake decode shared by the FSM and the queue bookkeeping.
  always_comb begin
    pop      = head_vld_q & bus.id_en & ~bus.redirect;
    push     = (state_q == WAIT) & bus.inst_rvalid & ~bus.redirect;
    remain   = OCC_W'(count_q) - OCC_W'(pop);
    occ_next = remain + OCC_W'(push);
    issue    = rst_n & ~bus.redirect & (occ_next < OCC_W'(DEPTH)) &
               ((state_q == IDLE) | ((state_q == WAIT) & bus.inst_rvalid));
    push_ent = '{pc: req_pc_q, inst: bus.inst_data};
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      req_pc_d   = fetch_pc_q;
    end
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_addr & ~ADDR_WIDTH'(3);
      if ((state_q == WAIT && !bus.inst_rvalid) || (state_q == DROP && !bus.inst_rvalid)) begin
        state_d = DROP;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE:    state_d = issue ? WAIT : IDLE;
        WAIT:    if (bus.inst_rvalid) state_d = issue ? WAIT : IDLE;
        DROP:    if (bus.inst_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // The head register is refreshed from the pushed entry when the queue would otherwise
  // be empty, else from storage; it keeps its last value once the queue drains.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    head_vld_d = head_vld_q;
    head_d     = head_q;
    if (bus.redirect) begin
      count_d    = '0;
      head_vld_d = 1'b0;
      rd_ptr_d   = wr_ptr_q;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_ent;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = CNT_W'(occ_next);
      if (occ_next != '0) begin
        head_vld_d = 1'b1;
        head_d     = (remain == '0) ? push_ent : mem_q[rd_ptr_d];
      end else begin
        head_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.inst_ren   = issue;
  assign bus.inst_addr  = fetch_pc_q;
  assign bus.id_valid   = head_vld_q;
  assign bus.id_inst    = head_q.inst;
  assign bus.id_pc      = head_q.pc;
  assign bus.id_pc_next = head_q.pc + ADDR_WIDTH'(4);
  assign bus.count      = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a default instance plus one with RESET_PC at the top of the address space.
// A small memory model answers each request after mem_lat cycles.
module tb_fetch_queue;
  logic clk;
  logic rst_n;

  fetch_queue_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) f ();
  fetch_queue_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) w ();

  fetch_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0))
    dut (.clk(clk), .rst_n(rst_n), .bus(f));
  fetch_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC))
    dut_w (.clk(clk), .rst_n(rst_n), .bus(w));

  int          n_chk = 0;
  int          n_err = 0;
  int          mem_lat = 1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          ren_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; requests seen this cycle feed the memory models for the next ones.
  task automatic tick();
    logic        ren_s, w_ren_s;
    logic [31:0] addr_s, w_addr_s;
    @(negedge clk);
    ren_s    = f.inst_ren;
    addr_s   = f.inst_addr;
    w_ren_s  = w.inst_ren;
    w_addr_s = w.inst_addr;
    @(posedge clk);
    #1;
    f.inst_rvalid = 1'b0;
    if (ren_s) begin
      pend      = 1'b1;
      pend_addr = addr_s;
      pend_cnt  = mem_lat;
    end
    if (pend) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        f.inst_rvalid = 1'b1;
        f.inst_data   = inst_of(pend_addr);
        pend          = 1'b0;
      end
    end
    w.inst_rvalid = w_ren_s;
    w.inst_data   = inst_of(w_addr_s);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    f.redirect      = 1'b0;
    f.redirect_addr = '0;
    f.id_en         = 1'b0;
    tick();
    tick();
    pend          = 1'b0;
    f.inst_rvalid = 1'b0;
    w.inst_rvalid = 1'b0;
    rst_n         = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    f.redirect      = 1'b0;
    f.redirect_addr = '0;
    f.inst_rvalid   = 1'b0;
    f.inst_data     = '0;
    f.id_en         = 1'b0;
    w.redirect      = 1'b0;
    w.redirect_addr = '0;
    w.inst_rvalid   = 1'b0;
    w.inst_data     = '0;
    w.id_en         = 1'b0;

    // Reset values, sampled while reset is still held.
    tick();
    tick();
    #1;
    check("rst_ren", f.inst_ren, 1'b0);
    check("rst_ren_w", w.inst_ren, 1'b0);
    check("rst_count", f.count, 3'd0);
    check("rst_valid", f.id_valid, 1'b0);
    check("rst_pc", f.id_pc, 32'h0);
    check("rst_inst", f.id_inst, 32'h0);
    check("rst_pc_next", f.id_pc_next, 32'h4);

    // Streaming with 1-cycle memory and a consumer that always accepts.
    rst_n   = 1'b1;
    f.id_en = 1'b1;
    mem_lat = 1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("seq_ren", f.inst_ren, 1'b1);
      check("seq_addr", f.inst_addr, 32'(4 * k));
      if (k == 1) check("seq_vld_low", f.id_valid, 1'b0);
      if (k >= 2) begin
        check("seq_vld", f.id_valid, 1'b1);
        check("seq_pc", f.id_pc, 32'(4 * (k - 2)));
        check("seq_inst", f.id_inst, inst_of(32'(4 * (k - 2))));
      end
      if (k == 5) check("seq_count", f.count, 3'd1);
      if (k == 0) check("wrap_addr0", w.inst_addr, 32'hFFFF_FFFC);
      if (k == 1) check("wrap_addr1", w.inst_addr, 32'h0);
      if (k == 2) begin
        check("wrap_head_pc", w.id_pc, 32'hFFFF_FFFC);
        check("wrap_pc_next", w.id_pc_next, 32'h0);
      end
      tick();
    end

    // Fill to full with no consumer, then a single pop frees room for one new request.
    do_reset();
    mem_lat = 1;
    ren_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (f.inst_ren) ren_cnt++;
      tick();
    end
    #1;
    check("fill_reqs", 64'(ren_cnt), 64'd4);
    check("fill_count", f.count, 3'd4);
    check("fill_ren", f.inst_ren, 1'b0);
    check("fill_head", f.id_pc, 32'h0);
    f.id_en = 1'b1;
    #1;
    check("pop_issue_ren", f.inst_ren, 1'b1);
    check("pop_issue_addr", f.inst_addr, 32'h10);
    tick();
    f.id_en = 1'b0;
    #1;
    check("pop_count", f.count, 3'd3);
    check("pop_head", f.id_pc, 32'h4);
    tick();
    #1;
    check("refill_count", f.count, 3'd4);

    // Redirect while a slow response is pending: that response must be dropped.
    do_reset();
    f.id_en = 1'b1;
    mem_lat = 3;
    #1;
    check("rd_issue_ren", f.inst_ren, 1'b1);
    check("rd_issue_addr", f.inst_addr, 32'h0);
    tick();
    f.redirect      = 1'b1;
    f.redirect_addr = 32'h1003;
    #1;
    check("rd_ren_blocked", f.inst_ren, 1'b0);
    tick();
    f.redirect = 1'b0;
    for (int k = 2; k < 8; k++) begin
      #1;
      if (k == 2 || k == 3) check("rd_drop_ren", f.inst_ren, 1'b0);
      if (k == 4) begin
        check("rd_new_ren", f.inst_ren, 1'b1);
        check("rd_new_addr", f.inst_addr, 32'h1000);
      end
      check("rd_count", f.count, 3'd0);
      check("rd_valid", f.id_valid, 1'b0);
      tick();
    end
    #1;
    check("rd_head_vld", f.id_valid, 1'b1);
    check("rd_head_pc", f.id_pc, 32'h1000);
    check("rd_head_inst", f.id_inst, inst_of(32'h1000));
    check("rd_head_count", f.count, 3'd1);

    // Redirect coinciding with a response and a pop at count 2.
    do_reset();
    mem_lat = 1;
    tick();
    tick();
    tick();
    #1;
    check("rdv_pre_count", f.count, 3'd2);
    f.redirect      = 1'b1;
    f.redirect_addr = 32'h2000;
    f.id_en         = 1'b1;
    #1;
    check("rdv_ren", f.inst_ren, 1'b0);
    tick();
    f.redirect = 1'b0;
    f.id_en    = 1'b0;
    #1;
    check("rdv_count", f.count, 3'd0);
    check("rdv_valid", f.id_valid, 1'b0);
    check("rdv_held_pc", f.id_pc, 32'h0);
    check("rdv_next_ren", f.inst_ren, 1'b1);
    check("rdv_next_addr", f.inst_addr, 32'h2000);
    tick();
    f.id_en = 1'b1;
    #1;
    check("rdv_wait_count", f.count, 3'd0);
    tick();
    #1;
    check("rdv_push_count", f.count, 3'd1);
    check("rdv_push_pc", f.id_pc, 32'h2000);
    check("rdv_push_vld", f.id_valid, 1'b1);
    f.id_en = 1'b0;

    // Reset with a request outstanding and three entries queued; its late response is ignored.
    do_reset();
    mem_lat = 2;
    for (int k = 0; k < 7; k++) tick();
    #1;
    check("mrst_pre_count", f.count, 3'd3);
    rst_n = 1'b0;
    #1;
    check("mrst_ren", f.inst_ren, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mrst_count", f.count, 3'd0);
    check("mrst_valid", f.id_valid, 1'b0);
    check("mrst_ren_restart", f.inst_ren, 1'b1);
    check("mrst_addr_restart", f.inst_addr, 32'h0);
    tick();
    #1;
    check("mrst_late_count", f.count, 3'd0);
    tick();
    #1;
    check("mrst_wait_count", f.count, 3'd0);
    tick();
    #1;
    check("mrst_push_count", f.count, 3'd1);
    check("mrst_push_pc", f.id_pc, 32'h0);
    check("mrst_push_inst", f.id_inst, inst_of(32'h0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH, 32, PC width; DATA_WIDTH, 32, instruction width; DEPTH, 4, queue entries (power of 2, >=2); RESET_PC, 0, first fetch address.
REQ-002 Ports (name, direction, width, meaning): clk, in, 1, sole clock, all state on rising edge.
REQ-003 rst_n, in, 1, reset; one clock; reset is synchronous and active-low.
REQ-004 redirect, in, 1, flush queue and restart fetch at redirect_addr.
REQ-005 redirect_addr, in, ADDR_WIDTH, new fetch PC; bits [1:0] ignored and treated as 0.
REQ-006 inst_ren, out, 1, single-cycle fetch request strobe.
REQ-007 inst_addr, out, ADDR_WIDTH, fetch address, meaningful only while inst_ren=1.
REQ-008 inst_rvalid, in, 1, response for the single outstanding request; arrives 1 or more cycles after the request.
REQ-009 inst_data, in, DATA_WIDTH, response instruction, qualified by inst_rvalid.
REQ-010 id_en, in, 1, consumer accept; pop occurs when id_valid & id_en.
REQ-011 id_valid, out, 1, queue head valid.
REQ-012 id_inst, out, DATA_WIDTH, head instruction.
REQ-013 id_pc, out, ADDR_WIDTH, head PC.
REQ-014 id_pc_next, out, ADDR_WIDTH, head PC + 4, modulo 2^ADDR_WIDTH.
REQ-015 count, out, clog2(DEPTH+1), current queue occupancy.

Function
REQ-016 FSM states: IDLE (no request outstanding), WAIT (one outstanding, response kept), DROP (one outstanding, response discarded).
REQ-017 At most one request is outstanding; inst_ren=1 only in IDLE, or in WAIT in the same cycle as inst_rvalid, and never while rst_n=0 or redirect=1.
REQ-018 Issue condition: occ_next < DEPTH, where occ_next = count + push - pop for the current cycle.
REQ-019 On issue: inst_addr=fetch_pc; fetch_pc <= fetch_pc+4 (wraps modulo 2^ADDR_WIDTH); state <= WAIT.
REQ-020 WAIT and inst_rvalid with no redirect: push {pc of request, inst_data}; state <= WAIT on re-issue, else IDLE; throughput 1 instruction/cycle with 1-cycle memory.
REQ-021 The queue is registered: a pushed entry is visible on id_* no earlier than the cycle after inst_rvalid; no combinational path exists from inst_data to id_inst.
REQ-022 Entries leave in fetch order; id_pc of consecutive entries differs by 4 unless separated by a redirect.
REQ-023 redirect=1: count <= 0, id_valid <= 0, pop ignored, inst_rvalid data in that cycle discarded, fetch_pc <= {redirect_addr[ADDR_WIDTH-1:2],2'b00}.
REQ-024 redirect=1 in state WAIT with inst_rvalid=0: state <= DROP; in state DROP, stay DROP; otherwise state <= IDLE.
REQ-025 DROP and inst_rvalid=1: discard data, no push, state <= IDLE; no issue that cycle.
REQ-026 Full (count=DEPTH): no issue, fetch_pc holds; simultaneous push and pop leaves count unchanged.
REQ-027 Empty: id_valid=0; id_en has no effect; id_inst, id_pc and id_pc_next hold their last values.
REQ-028 inst_rvalid while IDLE is a protocol error; it is ignored.

Reset
REQ-029 rst_n=0 at a clock edge: state <= IDLE, count <= 0, id_valid <= 0, fetch_pc <= RESET_PC, rd/wr pointers <= 0, id_inst/id_pc <= 0, id_pc_next <= 4; inst_ren=0 during reset.
REQ-030 Reset mid-operation discards any outstanding response; first inst_ren=1 with inst_addr=RESET_PC occurs in the first cycle with rst_n=1.

Verification
REQ-031 Reset release, 1-cycle memory, id_en=1 -> inst_addr 0,4,8,... on consecutive cycles; id_valid rises 2 cycles after the first request; id_pc 0,4,8 back-to-back.
REQ-032 id_en=0, DEPTH=4 -> exactly 4 pushes; count=4; inst_ren stays 0; id_en=1 for 1 cycle -> one pop and one new request issued in that same cycle.
REQ-033 redirect with redirect_addr=0x1003 while WAIT, response arrives 3 cycles later -> response discarded; next inst_addr=0x1000; count=0 until the 0x1000 data is pushed.
REQ-034 redirect coincident with inst_rvalid and a pop at count=2 -> count=0; no push; inst_ren=0 that cycle; 0x2000 is requested the next cycle.
REQ-035 RESET_PC=32'hFFFF_FFFC -> inst_addr FFFF_FFFC then 0; id_pc_next of the first entry = 0.
REQ-036 rst_n=0 asserted with a request outstanding and count=3 -> next cycle count=0 and id_valid=0; a late inst_rvalid is ignored; fetch restarts at RESET_PC.
